// File: rtl/game_state_controller_pkg.sv
// Shared state encodings, parameter defaults and width helper for the frog game controller.
package game_state_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_GAME_OVER = 3'd3,
    ST_PAUSED    = 3'd4
  } state_t;

  localparam int NUM_LANES_DEF  = 4;
  localparam int NUM_LIVES_DEF  = 3;
  localparam int SCORE_MAX_DEF  = 9;
  localparam int LEVEL_MAX_DEF  = 7;
  localparam int DEATH_HOLD_DEF = 25_000_000;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_state_controller_lane_enc.sv
// Lowest-set-bit encoder over the per-lane collision flags, plus an any-hit flag.
module game_state_controller_lane_enc
  import game_state_controller_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int IW        = idx_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] collide,
  output logic [IW-1:0]        idx,
  output logic                 any
);

  assign any = |collide;

  // Scan high to low so the last assignment is the lowest set lane.
  always_comb begin
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (collide[i]) idx = IW'(i);
  end

endmodule

// File: rtl/game_state_controller.sv
// Game flow FSM: start, lives, score/level, death hold and game over.
// Optional pause (RUNNING <-> PAUSED on i_Pause edges) is built only with GAME_PAUSE_EN.
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int NUM_LIVES  = NUM_LIVES_DEF,
  parameter int SCORE_MAX  = SCORE_MAX_DEF,
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int DEATH_HOLD = DEATH_HOLD_DEF
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic                         i_Start,
  input  logic [NUM_LANES-1:0]         i_Collide,
  input  logic                         i_Frog_Home,
  input  logic                         i_Pause,
  output logic [2:0]                   o_State,
  output logic                         o_Game_Active,
  output logic [2:0]                   o_Lives,
  output logic [3:0]                   o_Score,
  output logic [2:0]                   o_Level,
  output logic                         o_Level_Up,
  output logic                         o_Respawn,
  output logic [idx_w(NUM_LANES)-1:0]  o_Hit_Lane
);

  localparam int HW = idx_w(NUM_LANES);
  localparam int CW = idx_w(DEATH_HOLD);

  state_t         state;
  logic           start_q;
  logic [CW-1:0]  die_cnt;
  logic           any_hit;
  logic [HW-1:0]  hit_idx;
  logic           start_rise;

  assign start_rise = i_Start & ~start_q;
  assign o_State    = state;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  logic pause_rise;
  assign pause_rise = i_Pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = i_Pause;
`endif

  game_state_controller_lane_enc #(.NUM_LANES(NUM_LANES), .IW(HW)) u_lane_enc (
    .collide (i_Collide),
    .idx     (hit_idx),
    .any     (any_hit)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state         <= ST_IDLE;
      o_Game_Active <= 1'b0;
      o_Lives       <= '0;
      o_Score       <= '0;
      o_Level       <= '0;
      o_Level_Up    <= 1'b0;
      o_Respawn     <= 1'b0;
      o_Hit_Lane    <= '0;
      die_cnt       <= '0;
      // Edge register starts high so a start switch held through reset is not an edge.
      start_q       <= 1'b1;
`ifdef GAME_PAUSE_EN
      pause_q       <= 1'b1;
`endif
    end else begin
      start_q    <= i_Start;
      o_Level_Up <= 1'b0;
      o_Respawn  <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause_q    <= i_Pause;
`endif
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state         <= ST_RUNNING;
            o_Game_Active <= 1'b1;
            o_Lives       <= 3'(NUM_LIVES);
            o_Score       <= '0;
            o_Level       <= '0;
            o_Respawn     <= 1'b1;
          end
        end
        ST_RUNNING: begin
`ifdef GAME_PAUSE_EN
          if (pause_rise) begin
            state         <= ST_PAUSED;
            o_Game_Active <= 1'b0;
          end else
`endif
          if (any_hit) begin
            state         <= ST_DYING;
            o_Game_Active <= 1'b0;
            if (o_Lives != 3'd0) o_Lives <= o_Lives - 3'd1;
            o_Hit_Lane    <= hit_idx;
            die_cnt       <= '0;
          end else if (i_Frog_Home) begin
            o_Level_Up <= 1'b1;
            o_Respawn  <= 1'b1;
            if (o_Score == 4'(SCORE_MAX)) begin
              o_Score <= '0;
              if (o_Level != 3'(LEVEL_MAX)) o_Level <= o_Level + 3'd1;
            end else begin
              o_Score <= o_Score + 4'd1;
            end
          end
        end
        ST_DYING: begin
          if (die_cnt == CW'(DEATH_HOLD - 1)) begin
            die_cnt <= '0;
            if (o_Lives == 3'd0) begin
              state <= ST_GAME_OVER;
            end else begin
              state         <= ST_RUNNING;
              o_Game_Active <= 1'b1;
              o_Respawn     <= 1'b1;
            end
          end else begin
            die_cnt <= die_cnt + 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (!i_Start) state <= ST_IDLE;
        end
`ifdef GAME_PAUSE_EN
        ST_PAUSED: begin
          if (pause_rise) begin
            state         <= ST_RUNNING;
            o_Game_Active <= 1'b1;
          end
        end
`endif
        default: begin
          state         <= ST_IDLE;
          o_Game_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule
